// File: rtl/spi_pkg.sv
// Shared SPI link definitions: payload width, CS level, TX states.
// Imported by both ends of the 12-bit link.
package spi_pkg;

  localparam int SPI_DATA_W = 12;

  localparam logic CS_ACTIVE = 1'b0;
  localparam logic CS_IDLE   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    GAP
  } state_t;

  // Counter width that stays legal for a count of one.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Host request handshake plus the serial pins of the SPI transmitter.
// master = host side, slave = the transmitter.
interface spi_master_tx_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic              newd;
  logic [DATA_W-1:0] din;
  logic              ready;
  logic              done;
  logic              sync_clock;
  logic              CS;
  logic              MOSI;

  modport master (
    output newd,
    output din,
    input  ready,
    input  done,
    input  sync_clock,
    input  CS,
    input  MOSI
  );

  modport slave (
    input  newd,
    input  din,
    output ready,
    output done,
    output sync_clock,
    output CS,
    output MOSI
  );

endinterface

// File: rtl/spi_clk_div.sv
// Free-running serial clock divider with fall/rise strobes.
// Strobes are high in the clk cycle whose edge flips sync_clock.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic sync_clock,
  output logic fall_tick,
  output logic rise_tick
);

  localparam int CW = cw(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          wrap;

  assign wrap      = (cnt_q == LAST);
  assign fall_tick = wrap & sync_clock;
  assign rise_tick = wrap & ~sync_clock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      sync_clock <= 1'b0;
    end else if (wrap) begin
      cnt_q      <= '0;
      sync_clock <= ~sync_clock;
    end else begin
      cnt_q      <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_tx.sv
// SPI transmit end: latches a host word, sends it LSB-first with
// an arm edge before the data and a CS-high gap after it.
module spi_master_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = SPI_DATA_W,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_master_tx_if.slave bus
);

  localparam int BCW = cw(DATA_W);
  localparam int GCW = cw(GAP_CYC);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_W - 1);
  localparam logic [GCW-1:0] GC_LAST = GCW'(GAP_CYC - 1);

  logic sclk;
  logic fall_tick;
  logic unused_rise;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clock (sclk),
    .fall_tick  (fall_tick),
    .rise_tick  (unused_rise)
  );

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BCW-1:0]    bitcnt_q, bitcnt_d;
  logic [GCW-1:0]    gapcnt_q, gapcnt_d;
  logic              pending_q, pending_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              accept;

  assign accept = bus.newd & ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bitcnt_q  <= '0;
      gapcnt_q  <= '0;
      pending_q <= 1'b0;
      cs_q      <= CS_IDLE;
      mosi_q    <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bitcnt_q  <= bitcnt_d;
      gapcnt_q  <= gapcnt_d;
      pending_q <= pending_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bitcnt_d  = bitcnt_q;
    gapcnt_d  = gapcnt_q;
    pending_d = pending_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    // ready only rises in IDLE with nothing pending, so a
    // latch never collides with a shift below.
    if (accept) begin
      sreg_d    = bus.din;
      pending_d = 1'b1;
      ready_d   = 1'b0;
    end

    if (fall_tick) begin
      unique case (state_q)
        IDLE: begin
          if (pending_q) begin
            cs_d      = CS_ACTIVE;
            pending_d = 1'b0;
            state_d   = START;
          end
        end
        START: begin
          mosi_d   = sreg_q[0];
          sreg_d   = sreg_q >> 1;
          bitcnt_d = '0;
          state_d  = SEND;
        end
        SEND: begin
          if (bitcnt_q == BC_LAST) begin
            cs_d     = CS_IDLE;
            mosi_d   = 1'b0;
            done_d   = 1'b1;
            gapcnt_d = '0;
            state_d  = GAP;
          end else begin
            mosi_d   = sreg_q[0];
            sreg_d   = sreg_q >> 1;
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
        GAP: begin
          if (gapcnt_q == GC_LAST) begin
            state_d = IDLE;
            ready_d = 1'b1;
          end else begin
            gapcnt_d = gapcnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sync_clock = sclk;
  assign bus.CS         = cs_q;
  assign bus.MOSI       = mosi_q;
  assign bus.ready      = ready_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx with a behavioural SPI slave.
// Two instances: CLK_DIV=4/GAP_CYC=2 and CLK_DIV=1/GAP_CYC=1.
module tb_spi_master_tx;
  import spi_pkg::*;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_tx_if #(.DATA_W(W)) a_if ();
  spi_master_tx_if #(.DATA_W(W)) f_if ();

  spi_master_tx #(
    .DATA_W(W), .CLK_DIV(4), .GAP_CYC(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
  );

  spi_master_tx #(
    .DATA_W(W), .CLK_DIV(1), .GAP_CYC(1)
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .bus(f_if.slave)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // slave model: first rise with CS low arms, next W rises shift in
  int a_rcnt = 0;
  logic [W-1:0] a_sh, a_bits;
  logic [W-1:0] a_rxq[$];
  always @(posedge a_if.sync_clock) begin
    if (a_if.CS !== 1'b0) a_rcnt = 0;
    else begin
      if (a_rcnt > 0 && a_rcnt <= W) begin
        a_sh = {a_if.MOSI, a_sh[W-1:1]};
        a_bits[a_rcnt-1] = a_if.MOSI;
      end
      a_rcnt++;
      if (a_rcnt == W + 1) a_rxq.push_back(a_sh);
    end
  end

  int f_rcnt = 0;
  logic [W-1:0] f_sh, f_bits;
  logic [W-1:0] f_rxq[$];
  always @(posedge f_if.sync_clock) begin
    if (f_if.CS !== 1'b0) f_rcnt = 0;
    else begin
      if (f_rcnt > 0 && f_rcnt <= W) begin
        f_sh = {f_if.MOSI, f_sh[W-1:1]};
        f_bits[f_rcnt-1] = f_if.MOSI;
      end
      f_rcnt++;
      if (f_rcnt == W + 1) f_rxq.push_back(f_sh);
    end
  end

  int a_done_n = 0;
  always @(posedge clk) if (a_if.done === 1'b1) a_done_n++;

  int a_hi_run = 0;
  int a_hi_last = 0;
  always @(negedge clk) begin
    if (a_if.CS === 1'b1) a_hi_run++;
    else begin
      if (a_hi_run != 0) a_hi_last = a_hi_run;
      a_hi_run = 0;
    end
  end

  // CS/MOSI must hold across every sync_clock rising edge
  logic a_ps, a_pc, a_pm, f_ps, f_pc, f_pm;
  always @(negedge clk) begin
    if (rst_n && a_if.sync_clock && !a_ps)
      chk("a_rise_stable", {a_if.CS, a_if.MOSI}, {a_pc, a_pm});
    if (rst_n && f_if.sync_clock && !f_ps)
      chk("f_rise_stable", {f_if.CS, f_if.MOSI}, {f_pc, f_pm});
    a_ps = a_if.sync_clock; a_pc = a_if.CS; a_pm = a_if.MOSI;
    f_ps = f_if.sync_clock; f_pc = f_if.CS; f_pm = f_if.MOSI;
  end

  task automatic a_wait_ready();
    int n = 0;
    while (a_if.ready !== 1'b1 && n < 400) begin
      @(negedge clk); n++;
    end
    chk("a_ready_wait", a_if.ready, 1'b1);
  endtask

  task automatic a_send(input logic [W-1:0] w);
    a_wait_ready();
    a_if.din = w;
    a_if.newd = 1'b1;
    @(posedge clk);
    #1 a_if.newd = 1'b0;
  endtask

  task automatic a_wait_cs(input logic v, output int n);
    n = 0;
    while (a_if.CS !== v && n < 400) begin
      @(negedge clk); n++;
    end
    chk("a_cs_wait", a_if.CS, v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int exp_seq[W] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1};
  int n, lo, lat, d0, r0, tg, gmin, gmax, last_t;
  logic ps, csbad, dnbad;

  initial begin
    a_if.newd = 1'b0; a_if.din = '0;
    f_if.newd = 1'b0; f_if.din = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs", a_if.CS, 1'b1);
    chk("rst_sclk", a_if.sync_clock, 1'b0);
    chk("rst_mosi", a_if.MOSI, 1'b0);
    chk("rst_ready", a_if.ready, 1'b1);
    chk("rst_done", a_if.done, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;

    // idle for 50 clk
    @(negedge clk);
    ps = a_if.sync_clock; tg = 0; csbad = 0; dnbad = 0;
    gmin = 999; gmax = 0; last_t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_if.CS !== 1'b1) csbad = 1;
      if (a_if.done !== 1'b0) dnbad = 1;
      if (i < 48 && a_if.sync_clock !== ps) begin
        tg++;
        if (last_t >= 0) begin
          if (i - last_t < gmin) gmin = i - last_t;
          if (i - last_t > gmax) gmax = i - last_t;
        end
        last_t = i;
      end
      ps = a_if.sync_clock;
    end
    chk("idle_cs_high", csbad, 1'b0);
    chk("idle_no_done", dnbad, 1'b0);
    chk("idle_toggles", tg, 12);
    chk("idle_gap_min", gmin, 4);
    chk("idle_gap_max", gmax, 4);

    // frame 12'hA5C
    d0 = a_done_n; r0 = a_rxq.size();
    a_send(12'hA5C);
    @(negedge clk);
    chk("ready_drop", a_if.ready, 1'b0);
    a_wait_cs(1'b0, n);
    lat = n + 1;
    chk("latency_le9", (lat <= 9), 1'b1);
    lo = 0;
    while (a_if.CS === 1'b0 && lo < 300) begin
      lo++; @(negedge clk);
    end
    chk("cs_low_clk", lo, 104);
    chk("done_at_cs_rise", a_if.done, 1'b1);
    @(negedge clk);
    chk("done_one_clk", a_if.done, 1'b0);
    chk("done_count", a_done_n - d0, 1);
    chk("rx_count", a_rxq.size() - r0, 1);
    chk("rx_a5c", a_rxq[a_rxq.size()-1], 12'hA5C);
    for (int i = 0; i < W; i++)
      chk($sformatf("bit%0d", i), a_bits[i], exp_seq[i]);

    // newd held high during a frame
    a_wait_ready();
    d0 = a_done_n; r0 = a_rxq.size();
    a_if.din = 12'hA5C; a_if.newd = 1'b1;
    @(posedge clk); #1 a_if.din = 12'h123;
    n = 0;
    while (a_if.done !== 1'b1 && n < 300) begin
      @(negedge clk); n++;
    end
    chk("hold_done_seen", a_if.done, 1'b1);
    a_if.newd = 1'b0;
    repeat (200) @(negedge clk);
    chk("hold_rx_count", a_rxq.size() - r0, 1);
    chk("hold_rx_word", a_rxq[a_rxq.size()-1], 12'hA5C);
    chk("hold_done_count", a_done_n - d0, 1);
    chk("hold_idle_cs", a_if.CS, 1'b1);

    // back-to-back FFF then 001
    r0 = a_rxq.size();
    a_send(12'hFFF);
    @(negedge clk);
    a_wait_ready();
    a_send(12'h001);
    @(negedge clk);
    a_wait_cs(1'b0, n);
    @(negedge clk);
    chk("b2b_cs_high_clk", a_hi_last, 24);
    a_wait_cs(1'b1, n);
    chk("b2b_rx_count", a_rxq.size() - r0, 2);
    chk("b2b_rx_first", a_rxq[r0], 12'hFFF);
    chk("b2b_rx_second", a_rxq[r0+1], 12'h001);

    // reset mid-frame after bit 5 of 12'h555
    @(negedge clk);
    r0 = a_rxq.size();
    a_send(12'h555);
    @(negedge clk);
    n = 0;
    while (a_rcnt < 7 && n < 400) begin
      @(negedge clk); n++;
    end
    chk("mid_bits_seen", (a_rcnt >= 7), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", a_if.CS, 1'b1);
    chk("mid_rst_sclk", a_if.sync_clock, 1'b0);
    chk("mid_rst_mosi", a_if.MOSI, 1'b0);
    chk("mid_rst_ready", a_if.ready, 1'b1);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_rx", a_rxq.size() - r0, 0);
    a_send(12'h0AA);
    @(negedge clk);
    a_wait_cs(1'b0, n);
    a_wait_cs(1'b1, n);
    chk("mid_rx_count", a_rxq.size() - r0, 1);
    chk("mid_rx_0aa", a_rxq[a_rxq.size()-1], 12'h0AA);

    // CLK_DIV=1, GAP_CYC=1 instance
    @(negedge clk);
    ps = f_if.sync_clock; tg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (f_if.sync_clock !== ps) tg++;
      ps = f_if.sync_clock;
    end
    chk("fast_toggles", tg, 20);
    r0 = f_rxq.size();
    f_if.din = 12'h800; f_if.newd = 1'b1;
    @(posedge clk); #1 f_if.newd = 1'b0;
    n = 0;
    while (f_if.CS !== 1'b0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("fast_cs_fall", f_if.CS, 1'b0);
    lo = 0;
    while (f_if.CS === 1'b0 && lo < 100) begin
      lo++; @(negedge clk);
    end
    chk("fast_cs_low_clk", lo, 26);
    chk("fast_done", f_if.done, 1'b1);
    chk("fast_rx_count", f_rxq.size() - r0, 1);
    chk("fast_rx_800", f_rxq[f_rxq.size()-1], 12'h800);
    chk("fast_bit11", f_bits[11], 1'b1);
    chk("fast_bits_lo", f_bits[10:0], 11'h000);
    repeat (10) @(negedge clk);
    chk("fast_ready_back", f_if.ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
